// File: rtl/cpu_pkg.sv
// Shared LEGv8 front-end definitions: opcode fields, ALU encodings and the
// per-instruction control bundle handed to the datapath.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;

    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [4:0]  COND_LT = 5'h0B;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_B    = 2'd1,
        BR_CBZ  = 2'd2,
        BR_BLT  = 2'd3
    } br_t;

    typedef struct packed {
        logic       reg2loc;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       read_mem;
        logic       imm_size;
        logic       shift;
        logic [2:0] alu_op;
        logic       set_flags;
        logic       use_port2;
        br_t        br;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{
        reg2loc:    1'b1,
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        reg_write:  1'b0,
        mem_write:  1'b0,
        read_mem:   1'b0,
        imm_size:   1'b0,
        shift:      1'b0,
        alu_op:     ALU_PASS_B,
        set_flags:  1'b0,
        use_port2:  1'b0,
        br:         BR_NONE
    };

endpackage

// File: rtl/instr_decode.sv
// Combinational LEGv8 decoder: instruction word to control bundle and fields.
// Unsupported encodings fall through as a bubble.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rn,
    output logic [REG_W-1:0]   rm,
    output logic [8:0]         imm9,
    output logic [11:0]        imm12,
    output logic [5:0]         shamt,
    output logic [25:0]        imm26,
    output logic [18:0]        imm19
);

    assign rd    = instr[4:0];
    assign rn    = instr[9:5];
    assign rm    = instr[20:16];
    assign shamt = instr[15:10];
    assign imm12 = instr[21:10];
    assign imm9  = instr[20:12];
    assign imm26 = instr[25:0];
    assign imm19 = instr[23:5];

    always_comb begin
        ctrl = BUBBLE;
        if (instr[31:21] == OP_ADDS || instr[31:21] == OP_SUBS) begin
            ctrl.reg_write = 1'b1;
            ctrl.set_flags = 1'b1;
            ctrl.use_port2 = 1'b1;
            ctrl.alu_op    = (instr[31:21] == OP_ADDS) ? ALU_ADD : ALU_SUB;
        end else if (instr[31:21] == OP_AND || instr[31:21] == OP_EOR) begin
            ctrl.reg_write = 1'b1;
            ctrl.use_port2 = 1'b1;
            ctrl.alu_op    = (instr[31:21] == OP_AND) ? ALU_AND : ALU_XOR;
        end else if (instr[31:21] == OP_LSR) begin
            ctrl.reg_write = 1'b1;
            ctrl.shift     = 1'b1;
        end else if (instr[31:21] == OP_LDUR) begin
            ctrl.reg_write  = 1'b1;
            ctrl.read_mem   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.alu_op     = ALU_ADD;
        end else if (instr[31:21] == OP_STUR) begin
            // Store data travels on the second read port, addressed by Rd.
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
            ctrl.reg2loc   = 1'b0;
            ctrl.use_port2 = 1'b1;
        end else if (instr[31:22] == OP_ADDI) begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_size  = 1'b1;
            ctrl.alu_op    = ALU_ADD;
        end else if (instr[31:24] == OP_CBZ) begin
            ctrl.reg2loc   = 1'b0;
            ctrl.use_port2 = 1'b1;
            ctrl.br        = BR_CBZ;
        end else if (instr[31:24] == OP_BCOND && instr[4:0] == COND_LT) begin
            ctrl.br = BR_BLT;
        end else if (instr[31:26] == OP_B) begin
            ctrl.br = BR_B;
        end
    end

endmodule

// File: rtl/fetch_control.sv
// LEGv8 front end: PC, IF->RF register, RF-stage decode, flag register,
// branch resolution with one delay slot, and load-use stall.
module fetch_control
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              negative,
    input  logic              zero,
    input  logic              overflow,
    input  logic              carry_out,
    input  logic              CBZero,
    output logic [ADDR_W-1:0] pc,
    output logic [4:0]        Rd,
    output logic [4:0]        Rn,
    output logic [4:0]        Rm,
    output logic [8:0]        Imm9,
    output logic [11:0]       Imm12,
    output logic [5:0]        Shamt,
    output logic              Reg2Loc,
    output logic              AluSrc,
    output logic              MemToReg,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              readMem,
    output logic              ImmSize,
    output logic              shift,
    output logic [2:0]        AluOp
);

    logic [31:0]       ir_instr;
    logic [ADDR_W-1:0] ir_pc;
    logic              ex_read_mem;
    logic              ex_set_flags;
    logic [4:0]        ex_rd;
    logic [3:0]        flags;
    ctrl_t             dec_ctrl;
    logic [25:0]       imm26;
    logic [18:0]       imm19;
    logic [4:0]        port2_reg;
    logic              stall;
    logic              taken;
    logic              flag_n;
    logic              flag_v;
    logic [ADDR_W-1:0] br_offset;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;
    logic              unused_flags;

    instr_decode u_decode (
        .instr (ir_instr),
        .ctrl  (dec_ctrl),
        .rd    (Rd),
        .rn    (Rn),
        .rm    (Rm),
        .imm9  (Imm9),
        .imm12 (Imm12),
        .shamt (Shamt),
        .imm26 (imm26),
        .imm19 (imm19)
    );

    // Z and C are architectural state but nothing here branches on them.
    assign unused_flags = flags[2] ^ flags[0];

    // Load-use hazard against the LDUR currently in EX.
    always_comb begin
        port2_reg = dec_ctrl.reg2loc ? Rm : Rd;
        stall     = ex_read_mem && (ex_rd != 5'd31)
                    && ((ex_rd == Rn) || (dec_ctrl.use_port2 && (ex_rd == port2_reg)));
    end

    // Live flags win when the EX instruction is setting them this cycle.
    always_comb begin
        flag_n    = ex_set_flags ? negative : flags[3];
        flag_v    = ex_set_flags ? overflow : flags[1];
        br_offset = {{(ADDR_W-19){imm19[18]}}, imm19};
        taken     = 1'b0;
        case (dec_ctrl.br)
            BR_B: begin
                taken     = 1'b1;
                br_offset = {{(ADDR_W-26){imm26[25]}}, imm26};
            end
            BR_CBZ:  taken = CBZero;
            BR_BLT:  taken = flag_n ^ flag_v;
            default: taken = 1'b0;
        endcase
        taken  = taken && !stall;
        target = ir_pc + (br_offset << 2);
        if (stall) begin
            next_pc = pc;
        end else if (taken) begin
            next_pc = target;
        end else begin
            next_pc = pc + ADDR_W'(4);
        end
    end

    assign Reg2Loc  = dec_ctrl.reg2loc;
    assign AluSrc   = dec_ctrl.alu_src;
    assign ImmSize  = dec_ctrl.imm_size;
    assign shift    = dec_ctrl.shift;
    assign AluOp    = dec_ctrl.alu_op;
    assign MemToReg = dec_ctrl.mem_to_reg & ~stall;
    assign RegWrite = dec_ctrl.reg_write & ~stall;
    assign MemWrite = dec_ctrl.mem_write & ~stall;
    assign readMem  = dec_ctrl.read_mem & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= '0;
            ir_instr     <= '0;
            ir_pc        <= '0;
            ex_read_mem  <= 1'b0;
            ex_set_flags <= 1'b0;
            ex_rd        <= '0;
            flags        <= '0;
        end else begin
            pc <= next_pc;
            if (!stall) begin
                ir_instr <= instr;
                ir_pc    <= pc;
            end
            if (ex_set_flags) begin
                flags <= {negative, zero, overflow, carry_out};
            end
            ex_read_mem  <= readMem;
            ex_set_flags <= dec_ctrl.set_flags & ~stall;
            ex_rd        <= Rd;
        end
    end

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: small instruction ROM, per-cycle expected pc and
// enable scoreboard, plus targeted decode checks.
module tb_fetch_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        negative, zero, overflow, carry_out, CBZero;
    logic [63:0] pc;
    logic [4:0]  Rd, Rn, Rm;
    logic [8:0]  Imm9;
    logic [11:0] Imm12;
    logic [5:0]  Shamt;
    logic        Reg2Loc, AluSrc, MemToReg, RegWrite, MemWrite, readMem, ImmSize, shift;
    logic [2:0]  AluOp;

    logic [31:0] mem [0:63];

    typedef struct {
        logic [63:0] pc;
        logic        rw;
        logic        mw;
        logic        rm;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc;

    always #5 clk = ~clk;

    assign instr = mem[pc[7:2]];

    fetch_control #(.ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
        .CBZero(CBZero), .pc(pc), .Rd(Rd), .Rn(Rn), .Rm(Rm),
        .Imm9(Imm9), .Imm12(Imm12), .Shamt(Shamt),
        .Reg2Loc(Reg2Loc), .AluSrc(AluSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .readMem(readMem), .ImmSize(ImmSize), .shift(shift),
        .AluOp(AluOp)
    );

    function automatic exp_t mk(input longint unsigned p, input logic rw, input logic rm);
        exp_t r;
        r.pc = 64'(p);
        r.rw = rw;
        r.mw = 1'b0;
        r.rm = rm;
        return r;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        negative = 0; zero = 0; overflow = 0; carry_out = 0; CBZero = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(4, 0, 0));
        exp_q.push_back(mk(8, 0, 0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || RegWrite !== e.rw || MemWrite !== e.mw || readMem !== e.rm) begin
                failures++;
                $display("FAIL reset_seq cyc=%0d got pc=%0d rw=%b mw=%b rm=%b want pc=%0d rw=%b mw=%b rm=%b",
                         cyc, pc, RegWrite, MemWrite, readMem, e.pc, e.rw, e.mw, e.rm);
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_addi();
        clear_mem();
        mem[0] = {10'b1001000100, 12'd5, 5'd31, 5'd1};
        do_reset();
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(4, 1, 0));
        exp_q.push_back(mk(8, 0, 0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || RegWrite !== e.rw || MemWrite !== e.mw || readMem !== e.rm) begin
                failures++;
                $display("FAIL addi_seq cyc=%0d got pc=%0d rw=%b mw=%b rm=%b want pc=%0d rw=%b mw=%b rm=%b",
                         cyc, pc, RegWrite, MemWrite, readMem, e.pc, e.rw, e.mw, e.rm);
            end
            if (cyc == 1) begin
                checks++;
                if (AluSrc !== 1'b1 || ImmSize !== 1'b1 || AluOp !== 3'b010 || Rd !== 5'd1 ||
                    Rn !== 5'd31 || Imm12 !== 12'd5 || shift !== 1'b0 || MemToReg !== 1'b0) begin
                    failures++;
                    $display("FAIL addi_decode got alusrc=%b immsize=%b aluop=%b rd=%0d rn=%0d imm12=%0d shift=%b m2r=%b want 1 1 010 1 31 5 0 0",
                             AluSrc, ImmSize, AluOp, Rd, Rn, Imm12, shift, MemToReg);
                end
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    // B +3 at 8, then CBZ X2,+off at 24 with CBZero held at cbz_val.
    task automatic test_branch(input logic cbz_val, input int off);
        clear_mem();
        mem[2] = {6'b000101, 26'd3};
        mem[6] = {8'b10110100, 19'(off), 5'd2};
        CBZero = cbz_val;
        do_reset();
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(4, 0, 0));
        exp_q.push_back(mk(8, 0, 0));
        exp_q.push_back(mk(12, 0, 0));
        exp_q.push_back(mk(20, 0, 0));
        exp_q.push_back(mk(24, 0, 0));
        exp_q.push_back(mk(28, 0, 0));
        exp_q.push_back(mk(cbz_val ? 64'(24 + 4 * off) : 64'd32, 0, 0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || RegWrite !== e.rw || MemWrite !== e.mw || readMem !== e.rm) begin
                failures++;
                $display("FAIL branch_seq cbz=%b off=%0d cyc=%0d got pc=%0d rw=%b mw=%b rm=%b want pc=%0d rw=%b mw=%b rm=%b",
                         cbz_val, off, cyc, pc, RegWrite, MemWrite, readMem, e.pc, e.rw, e.mw, e.rm);
            end
            if (cyc == 6) begin
                checks++;
                if (Reg2Loc !== 1'b0 || Rd !== 5'd2) begin
                    failures++;
                    $display("FAIL cbz_decode got reg2loc=%b rd=%0d want 0 2", Reg2Loc, Rd);
                end
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_load_use();
        clear_mem();
        mem[0] = {11'b11111000010, 9'd0, 2'b00, 5'd1, 5'd3};
        mem[1] = {11'b10101011000, 5'd3, 6'd0, 5'd3, 5'd4};
        do_reset();
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(4, 1, 1));
        exp_q.push_back(mk(8, 0, 0));
        exp_q.push_back(mk(8, 1, 0));
        exp_q.push_back(mk(12, 0, 0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || RegWrite !== e.rw || MemWrite !== e.mw || readMem !== e.rm) begin
                failures++;
                $display("FAIL load_use_seq cyc=%0d got pc=%0d rw=%b mw=%b rm=%b want pc=%0d rw=%b mw=%b rm=%b",
                         cyc, pc, RegWrite, MemWrite, readMem, e.pc, e.rw, e.mw, e.rm);
            end
            if (cyc == 1) begin
                checks++;
                if (MemToReg !== 1'b1 || AluSrc !== 1'b1 || ImmSize !== 1'b0 || AluOp !== 3'b010 ||
                    Rd !== 5'd3 || Rn !== 5'd1 || Imm9 !== 9'd0) begin
                    failures++;
                    $display("FAIL ldur_decode got m2r=%b alusrc=%b immsize=%b aluop=%b rd=%0d rn=%0d imm9=%0d want 1 1 0 010 3 1 0",
                             MemToReg, AluSrc, ImmSize, AluOp, Rd, Rn, Imm9);
                end
            end
            if (cyc == 3) begin
                checks++;
                if (Rn !== 5'd3 || Rm !== 5'd3 || Rd !== 5'd4 || AluOp !== 3'b010 ||
                    Reg2Loc !== 1'b1 || Shamt !== 6'd0) begin
                    failures++;
                    $display("FAIL adds_issue got rn=%0d rm=%0d rd=%0d aluop=%b reg2loc=%b shamt=%0d want 3 3 4 010 1 0",
                             Rn, Rm, Rd, AluOp, Reg2Loc, Shamt);
                end
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    // SUBS X5,X1,X1 then B.LT (gap=1 puts a bubble between so the flag register is used).
    task automatic test_blt(input logic gap, input logic n_ex, input logic n_other);
        longint unsigned tgt;
        clear_mem();
        mem[0] = {11'b11101011000, 5'd1, 6'd0, 5'd1, 5'd5};
        if (gap) mem[2] = {8'b01010100, 19'd4, 5'h0B};
        else     mem[1] = {8'b01010100, 19'd4, 5'h0B};
        tgt = gap ? 24 : 20;
        do_reset();
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(4, 1, 0));
        exp_q.push_back(mk(8, 0, 0));
        if (gap) begin
            exp_q.push_back(mk(12, 0, 0));
            exp_q.push_back(mk(n_ex ? tgt : 16, 0, 0));
        end else begin
            exp_q.push_back(mk(n_ex ? tgt : 12, 0, 0));
            exp_q.push_back(mk(n_ex ? tgt + 4 : 16, 0, 0));
        end
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || RegWrite !== e.rw || MemWrite !== e.mw || readMem !== e.rm) begin
                failures++;
                $display("FAIL blt_seq gap=%b n_ex=%b n_other=%b cyc=%0d got pc=%0d rw=%b want pc=%0d rw=%b",
                         gap, n_ex, n_other, cyc, pc, RegWrite, e.pc, e.rw);
            end
            if (cyc == 1) begin
                checks++;
                if (AluOp !== 3'b011 || Rd !== 5'd5) begin
                    failures++;
                    $display("FAIL subs_decode got aluop=%b rd=%0d want 011 5", AluOp, Rd);
                end
            end
            zero     = 1'b1;
            overflow = 1'b0;
            negative = (cyc == 2) ? n_ex : n_other;
            @(negedge clk);
            cyc++;
        end
    endtask

    // LDUR X2 then CBZ X2: stall and branch collide; CBZero changes across the stall.
    task automatic test_stall_branch(input logic cbz_stall, input logic cbz_after);
        clear_mem();
        mem[0] = {11'b11111000010, 9'd0, 2'b00, 5'd1, 5'd2};
        mem[1] = {8'b10110100, 19'd4, 5'd2};
        do_reset();
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(4, 1, 1));
        exp_q.push_back(mk(8, 0, 0));
        exp_q.push_back(mk(8, 0, 0));
        exp_q.push_back(mk(cbz_after ? 64'd20 : 64'd12, 0, 0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || RegWrite !== e.rw || MemWrite !== e.mw || readMem !== e.rm) begin
                failures++;
                $display("FAIL stall_branch cbz=%b/%b cyc=%0d got pc=%0d rw=%b rm=%b want pc=%0d rw=%b rm=%b",
                         cbz_stall, cbz_after, cyc, pc, RegWrite, readMem, e.pc, e.rw, e.rm);
            end
            CBZero = (cyc == 2) ? cbz_stall : cbz_after;
            @(negedge clk);
            cyc++;
        end
    endtask

    // Reset asserted while a stall (branch_case=0) or a taken branch (=1) is live.
    task automatic test_reset_priority(input logic branch_case);
        int rst_cyc;
        clear_mem();
        if (branch_case) begin
            mem[2] = {6'b000101, 26'd3};
            rst_cyc = 3;
            exp_q.push_back(mk(0, 0, 0));
            exp_q.push_back(mk(4, 0, 0));
            exp_q.push_back(mk(8, 0, 0));
            exp_q.push_back(mk(12, 0, 0));
            exp_q.push_back(mk(0, 0, 0));
            exp_q.push_back(mk(4, 0, 0));
        end else begin
            mem[0] = {11'b11111000010, 9'd0, 2'b00, 5'd1, 5'd3};
            mem[1] = {11'b10101011000, 5'd3, 6'd0, 5'd3, 5'd4};
            rst_cyc = 2;
            exp_q.push_back(mk(0, 0, 0));
            exp_q.push_back(mk(4, 1, 1));
            exp_q.push_back(mk(8, 0, 0));
            exp_q.push_back(mk(0, 0, 0));
            exp_q.push_back(mk(4, 1, 1));
        end
        do_reset();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || RegWrite !== e.rw || MemWrite !== e.mw || readMem !== e.rm) begin
                failures++;
                $display("FAIL reset_priority br=%b cyc=%0d got pc=%0d rw=%b rm=%b want pc=%0d rw=%b rm=%b",
                         branch_case, cyc, pc, RegWrite, readMem, e.pc, e.rw, e.rm);
            end
            reset = (cyc == rst_cyc);
            @(negedge clk);
            cyc++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_mem();
        test_reset();
        test_addi();
        test_branch(1'b1, 2);
        test_branch(1'b0, 2);
        test_branch(1'b1, 4);
        test_branch(1'b0, 4);
        test_load_use();
        test_blt(1'b0, 1'b0, 1'b0);
        test_blt(1'b0, 1'b1, 1'b0);
        test_blt(1'b1, 1'b1, 1'b0);
        test_blt(1'b1, 1'b0, 1'b1);
        test_stall_branch(1'b1, 1'b0);
        test_stall_branch(1'b0, 1'b1);
        test_reset_priority(1'b0);
        test_reset_priority(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
